cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Sits at the consumer end of the ALU interface. Takes the 4-bit ALU flag vector {N,Z,C,V} and holds it in an architectural flag register.
- Evaluates the instruction's 4-bit condition code against the held flags.
- Gates the PC-source, register-write and memory-write controls through a one-stage registered pipeline with stall and flush.
- Feeds the writeback and fetch logic of the single-issue datapath.

Parameters:
- FLAG_W, 4, width of the flag vector; fixed ordering {N,Z,C,V}, MSB first.
- RESET_FLAGS, 4'b0000, value loaded into the flag register on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all state; no flag update; outputs keep their values.
- flush  in  1  kill the current instruction; takes priority below rst and above stall.
- valid_in  in  1  the Cond, ALUFlags and control inputs describe a live instruction this cycle.
- Cond  in  4  instruction condition code.
- ALUFlags  in  4  {N,Z,C,V} from the ALU for this instruction.
- FlagW  in  2  [1] allows an N,Z update; [0] allows a C,V update.
- PCS  in  1  instruction writes the PC.
- RegW  in  1  instruction writes the register file.
- MemW  in  1  instruction writes memory.
- NoWrite  in  1  compare-type instruction; suppresses RegWrite only.
- CondEx  out  1  combinational: Cond evaluated against the current flag register.
- valid_out  out  1  registered: the gated controls below are live.
- PCSrc  out  1  registered: PCS & CondEx.
- RegWrite  out  1  registered: RegW & CondEx & ~NoWrite.
- MemWrite  out  1  registered: MemW & CondEx.
- Flags  out  4  current architectural flag register {N,Z,C,V}.

Behaviour:
- Reset (rst=1 at an edge):
  - Flags = RESET_FLAGS.
  - valid_out, PCSrc, RegWrite and MemWrite = 0.
  - rst overrides stall and flush.
- CondEx truth table, combinational from Flags only (never from ALUFlags):
  - 0000 EQ Z
  - 0001 NE ~Z
  - 0010 CS C
  - 0011 CC ~C
  - 0100 MI N
  - 0101 PL ~N
  - 0110 VS V
  - 0111 VC ~V
  - 1000 HI C&~Z
  - 1001 LS ~C|Z
  - 1010 GE N==V
  - 1011 LT N!=V
  - 1100 GT ~Z&(N==V)
  - 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 treated as AL, 1
- Update condition: upd = valid_in & CondEx & ~stall & ~flush.
- Flag update at the edge when upd:
  - If FlagW[1]: N,Z <= ALUFlags[3:2].
  - If FlagW[0]: C,V <= ALUFlags[1:0].
  - Unselected halves hold.
  - A failed condition never updates flags, even with FlagW set.
- Output pipeline, one-cycle latency:
  - Normal cycle (~stall & ~flush): valid_out <= valid_in; PCSrc, RegWrite and MemWrite <= their gated values ANDed with valid_in.
  - stall=1 & flush=0: every register holds, including Flags.
  - flush=1: valid_out, PCSrc, RegWrite and MemWrite <= 0; Flags hold; flush overrides stall.
- Condition timing:
  - Back-to-back instructions: the instruction at cycle t sees flags written by the instruction accepted at t-1.
  - There is no forwarding of ALUFlags into CondEx.
- valid_in=0: gated outputs register 0 and Flags hold.
- Reset mid-stall or mid-flush: reset wins; the next cycle starts clean.

Decomposition:
- Shared package cond_pkg:
  - enum cond_e with the 16 codes above.
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef flags_t as logic [3:0].
- One combinational sub-module, cond_check:
  - Inputs: Cond, Flags. Output: CondEx.
  - Reused by the branch predictor later.
- The top module holds the flag register and the output pipeline register.

Test Plan:
1. Reset → Flags=0000, outputs 0. Then Cond=0000 (EQ) with Z=0 → CondEx=0. Then an instruction with Cond=1110, FlagW=11, ALUFlags=0100 → next cycle Flags=0100 and CondEx for EQ reads 1.
2. Partial write: Flags=1111, then FlagW=10 with ALUFlags=0000 → Flags=0011. Then FlagW=01 with ALUFlags=0000 → Flags=0000.
3. Failed condition: Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, RegW=1, MemW=1 → Flags stay 0000; next cycle valid_out=1, RegWrite=0, MemWrite=0.
4. Signed compare sweep: load Flags 1001 → GE=1, LT=0, GT=1, LE=0. Load Flags 1101 → GT=0, LE=1. Load Flags 0010 → HI=1, LS=0.
5. Stall/flush: valid instruction with Cond=AL, PCS=1 → PCSrc=1 next cycle. Assert stall 3 cycles → PCSrc stays 1 and Flags are unchanged despite FlagW=11. Assert stall and flush together → PCSrc=0, valid_out=0, Flags unchanged.
6. NoWrite: Cond=AL, RegW=1, NoWrite=1, FlagW=11, ALUFlags=0100 → RegWrite=0 next cycle and Flags=0100. Assert rst in the same cycle as a flag-writing instruction → Flags=RESET_FLAGS.

Source files
------------

// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition-code and flag definitions
package cond_pkg;

  // Condition codes; 1111 behaves as always
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Bit positions inside the {N,Z,C,V} vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational condition-code evaluator
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = Flags[FLAG_N];
  assign w_z = Flags[FLAG_Z];
  assign w_c = Flags[FLAG_C];
  assign w_v = Flags[FLAG_V];

  // Decode the condition code against the held flags
  always_comb begin
    CondEx = 1'b1;
    case (cond_e'(Cond))
      COND_EQ: CondEx = w_z;
      COND_NE: CondEx = ~w_z;
      COND_CS: CondEx = w_c;
      COND_CC: CondEx = ~w_c;
      COND_MI: CondEx = w_n;
      COND_PL: CondEx = ~w_n;
      COND_VS: CondEx = w_v;
      COND_VC: CondEx = ~w_v;
      COND_HI: CondEx = w_c & ~w_z;
      COND_LS: CondEx = ~w_c | w_z;
      COND_GE: CondEx = (w_n == w_v);
      COND_LT: CondEx = (w_n != w_v);
      COND_GT: CondEx = ~w_z & (w_n == w_v);
      COND_LE: CondEx = w_z | (w_n != w_v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - flag register, condition check and gated control pipeline
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int                FLAG_W      = 4,
  parameter logic [FLAG_W-1:0] RESET_FLAGS = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [3:0]        Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  output logic              CondEx,
  output logic              valid_out,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic [FLAG_W-1:0] Flags
);

  flags_t r_flags;
  logic   r_valid;
  logic   r_pcsrc;
  logic   r_regwrite;
  logic   r_memwrite;
  logic   w_cond_ex;
  logic   w_upd;

  // Condition is judged only on the architectural flags, never on ALUFlags
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (r_flags),
    .CondEx (w_cond_ex)
  );

  assign w_upd = valid_in & w_cond_ex & ~stall & ~flush;

  // Flag register and one-stage control pipeline; rst > flush > stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags    <= RESET_FLAGS;
      r_valid    <= 1'b0;
      r_pcsrc    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_pcsrc    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (!stall) begin
      if (w_upd && FlagW[1]) begin
        r_flags[FLAG_N] <= ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (w_upd && FlagW[0]) begin
        r_flags[FLAG_C] <= ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
      r_valid    <= valid_in;
      r_pcsrc    <= valid_in & PCS & w_cond_ex;
      r_regwrite <= valid_in & RegW & w_cond_ex & ~NoWrite;
      r_memwrite <= valid_in & MemW & w_cond_ex;
    end
  end

  assign CondEx    = w_cond_ex;
  assign valid_out = r_valid;
  assign PCSrc     = r_pcsrc;
  assign RegWrite  = r_regwrite;
  assign MemWrite  = r_memwrite;
  assign Flags     = r_flags;

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - self-checking bench for cond_flag_unit
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [3:0] Cond = 4'h0, ALUFlags = 4'h0;
  logic [1:0] FlagW = 2'b00;
  logic       PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
  logic       CondEx, valid_out, PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] m_flags;
  logic       m_vo, m_pc, m_rw, m_mw;
  logic       obs_ce;

  cond_flag_unit #(.FLAG_W(4), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .CondEx(CondEx), .valid_out(valid_out),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Conditions come in pairs: even code = base test, odd code = its negation
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b1;
    case (c >> 1)
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  // One clock cycle: drive, check CondEx, advance model, check registered state
  task automatic step(input logic r, input logic s, input logic fl, input logic vi,
                      input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                      input logic pcs, input logic rw, input logic mw, input logic nw);
    logic ce;
    @(negedge clk);
    rst = r; stall = s; flush = fl; valid_in = vi; Cond = c; ALUFlags = af;
    FlagW = fw; PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
    #1;
    obs_ce = CondEx;
    ce = ref_cond(c, m_flags);
    if (!r) check("CondEx", {31'b0, CondEx}, {31'b0, ce});
    if (r) begin
      m_flags = 4'b0000;
      m_vo = 0; m_pc = 0; m_rw = 0; m_mw = 0;
    end else if (fl) begin
      m_vo = 0; m_pc = 0; m_rw = 0; m_mw = 0;
    end else if (!s) begin
      if (vi && ce) begin
        if (fw[1]) m_flags = {af[3:2], m_flags[1:0]};
        if (fw[0]) m_flags = {m_flags[3:2], af[1:0]};
      end
      m_vo = vi;
      m_pc = vi & pcs & ce;
      m_rw = vi & rw & ce & ~nw;
      m_mw = vi & mw & ce;
    end
    @(posedge clk);
    #1;
    check("Flags",     {28'b0, Flags},     {28'b0, m_flags});
    check("valid_out", {31'b0, valid_out}, {31'b0, m_vo});
    check("PCSrc",     {31'b0, PCSrc},     {31'b0, m_pc});
    check("RegWrite",  {31'b0, RegWrite},  {31'b0, m_rw});
    check("MemWrite",  {31'b0, MemWrite},  {31'b0, m_mw});
  endtask

  // Idle cycle that probes a condition code against a known constant
  task automatic probe(input string tag, input logic [3:0] c, input logic exp);
    step(0, 0, 0, 0, c, 4'h0, 2'b00, 0, 0, 0, 0);
    check(tag, {31'b0, obs_ce}, {31'b0, exp});
  endtask

  // Valid always-executed instruction writing the given flag halves
  task automatic load(input logic [3:0] af, input logic [1:0] fw);
    step(0, 0, 0, 1, 4'hE, af, fw, 0, 0, 0, 0);
  endtask

  initial begin
    m_flags = 4'b0000;
    m_vo = 0; m_pc = 0; m_rw = 0; m_mw = 0;

    // 1: reset, EQ with Z=0, then set Z
    step(1, 1, 1, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
    check("reset_flags", {28'b0, Flags}, 32'h0);
    probe("eq_z0", 4'h0, 1'b0);
    load(4'b0100, 2'b11);
    check("t1_flags", {28'b0, Flags}, 32'h4);
    probe("eq_z1", 4'h0, 1'b1);

    // 2: partial writes
    load(4'b1111, 2'b11);
    load(4'b0000, 2'b10);
    check("t2_nz_only", {28'b0, Flags}, 32'h3);
    load(4'b0000, 2'b01);
    check("t2_cv_only", {28'b0, Flags}, 32'h0);

    // 3: failed condition blocks flag update and gated writes
    step(0, 0, 0, 1, 4'h0, 4'hF, 2'b11, 0, 1, 1, 0);
    check("t3_flags", {28'b0, Flags}, 32'h0);
    check("t3_valid", {31'b0, valid_out}, 32'h1);
    check("t3_regw",  {31'b0, RegWrite},  32'h0);
    check("t3_memw",  {31'b0, MemWrite},  32'h0);

    // 4: signed and unsigned compares
    load(4'b1001, 2'b11);
    probe("ge_1001", 4'hA, 1'b1);
    probe("lt_1001", 4'hB, 1'b0);
    probe("gt_1001", 4'hC, 1'b1);
    probe("le_1001", 4'hD, 1'b0);
    load(4'b1101, 2'b11);
    probe("gt_1101", 4'hC, 1'b0);
    probe("le_1101", 4'hD, 1'b1);
    load(4'b0010, 2'b11);
    probe("hi_0010", 4'h8, 1'b1);
    probe("ls_0010", 4'h9, 1'b0);

    // 5: stall holds everything, flush beats stall
    step(0, 0, 0, 1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0);
    check("t5_pcsrc", {31'b0, PCSrc}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 4'hE, 4'b1101, 2'b11, 0, 1, 1, 0);
      check("t5_stall_pcsrc", {31'b0, PCSrc}, 32'h1);
      check("t5_stall_flags", {28'b0, Flags}, 32'h2);
    end
    step(0, 1, 1, 1, 4'hE, 4'b1101, 2'b11, 1, 1, 1, 0);
    check("t5_flush_pcsrc", {31'b0, PCSrc}, 32'h0);
    check("t5_flush_valid", {31'b0, valid_out}, 32'h0);
    check("t5_flush_flags", {28'b0, Flags}, 32'h2);

    // 6: NoWrite suppresses only RegWrite; reset beats a flag write
    step(0, 0, 0, 1, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1);
    check("t6_regw",  {31'b0, RegWrite}, 32'h0);
    check("t6_flags", {28'b0, Flags}, 32'h4);
    step(1, 0, 0, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
    check("t6_rst_flags", {28'b0, Flags}, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
